// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: converts a packed BCD word to binary one digit per clock, MSD first,
// and flags any nibble above 9.
module bcd_to_binary_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [4*DIGITS-1:0]   BCD,
    output logic                  Busy,
    output logic                  Done,
    output logic [BIN_W-1:0]      Binary,
    output logic                  Error
);
    localparam int CNT_W = DIGITS > 1 ? $clog2(DIGITS) : 1;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t              state, state_n;
    logic [4*DIGITS-1:0] sh, sh_n;
    logic [BIN_W-1:0]    acc, acc_n, bin_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                err, err_n, done_n, error_n;
    logic [3:0]          digit;
    logic [BIN_W+3:0]    prod;
    assign digit = sh[4*DIGITS-1 -: 4];
    assign prod  = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{BIN_W{1'b0}}, digit};
    assign Busy  = state != IDLE;
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            sh     <= '0;
            acc    <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            Done   <= 1'b0;
            Binary <= '0;
            Error  <= 1'b0;
        end else begin
            state  <= state_n;
            sh     <= sh_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            err    <= err_n;
            Done   <= done_n;
            Binary <= bin_n;
            Error  <= error_n;
        end
    end
    always_comb begin
        state_n = state;
        sh_n    = sh;
        acc_n   = acc;
        cnt_n   = cnt;
        err_n   = err;
        done_n  = 1'b0;
        bin_n   = Binary;
        error_n = Error;
        case (state)
            IDLE: if (Start) begin
                sh_n    = BCD;
                acc_n   = '0;
                cnt_n   = '0;
                err_n   = 1'b0;
                state_n = CONV;
            end
            CONV: begin
                acc_n = prod[BIN_W-1:0];
                err_n = err | (digit > 4'd9);
                sh_n  = sh << 4;
                cnt_n = cnt + 1'b1;
                // Last digit: publish result on this same edge so Done lines up with DONE.
                if (cnt == CNT_W'(DIGITS - 1)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    bin_n   = err_n ? '0 : acc_n;
                    error_n = err_n;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq: directed checks of conversion latency, results, error flag, reset abort.
module tb_bcd_to_binary_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] bcd = '0;
    logic        busy, done, err;
    logic [9:0]  bin;
    logic        start4 = 1'b0;
    logic [15:0] bcd4 = '0;
    logic        busy4, done4, err4;
    logic [13:0] bin4;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .Clock(clk), .Reset(rst), .Start(start), .BCD(bcd),
        .Busy(busy), .Done(done), .Binary(bin), .Error(err)
    );

    bcd_to_binary_seq #(.DIGITS(4), .BIN_W(14)) dut4 (
        .Clock(clk), .Reset(rst), .Start(start4), .BCD(bcd4),
        .Busy(busy4), .Done(done4), .Binary(bin4), .Error(err4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [11:0] v, input logic [9:0] eb, input logic ee, input string tag);
        bcd = v;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        repeat (2) begin
            @(posedge clk); #1 check({tag, "_early"}, done, 0);
        end
        @(posedge clk); #1;
        check({tag, "_done"}, done, 1);
        check({tag, "_bin"}, bin, eb);
        check({tag, "_err"}, err, ee);
        check({tag, "_busy_done"}, busy, 1);
        @(posedge clk); #1;
        check({tag, "_done_off"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bin", bin, 0);
        check("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run(12'h999, 10'd999, 1'b0, "t2_999");
        run(12'h000, 10'd0, 1'b0, "t3_000");
        run(12'h001, 10'd1, 1'b0, "t3_001");
        run(12'h100, 10'd100, 1'b0, "t3_100");
        run(12'h1A5, 10'd0, 1'b1, "t4_1a5");
        repeat (3) @(posedge clk);
        #1 check("t4_hold_err", err, 1);
        check("t4_hold_bin", bin, 0);
        run(12'h042, 10'd42, 1'b0, "t4_042");
        // Start pulses and BCD change during conversion must be ignored
        bcd = 12'h250;
        start = 1'b1;
        @(posedge clk); #1 bcd = 12'h777;
        @(posedge clk); #1 start = 1'b0;
        check("t5_nodone1", done, 0);
        @(posedge clk); #1 start = 1'b1;
        check("t5_nodone2", done, 0);
        @(posedge clk); #1 start = 1'b0;
        check("t5_done", done, 1);
        check("t5_bin", bin, 250);
        check("t5_err", err, 0);
        @(posedge clk); #1 check("t5_done_off", done, 0);
        check("t5_idle", busy, 0);
        @(posedge clk); #1 check("t5_single", done, 0);
        check("t5_hold", bin, 250);
        // Reset mid-conversion aborts with no Done
        bcd = 12'h123;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_bin", bin, 0);
        check("t6_rst_done", done, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1 check("t6_no_done", done, 0);
        end
        run(12'h456, 10'd456, 1'b0, "t6_456");
        // Continuous Start: back-to-back conversions every DIGITS+2 cycles
        bcd = 12'h321;
        start = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 check("hold_done1", done, 1);
        check("hold_bin1", bin, 321);
        @(posedge clk); #1 check("hold_idle", busy, 0);
        bcd = 12'h654;
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        check("hold_done2", done, 1);
        check("hold_bin2", bin, 654);
        @(posedge clk); #1;
        // Four-digit variant
        bcd4 = 16'h9999;
        start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1 check("d4_early", done4, 0);
        end
        @(posedge clk); #1;
        check("d4_done", done4, 1);
        check("d4_bin", bin4, 14'h270F);
        check("d4_err", err4, 0);
        @(posedge clk); #1 check("d4_idle", busy4, 0);
        bcd4 = 16'h12B4;
        start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("d4_bad_done", done4, 1);
        check("d4_bad_err", err4, 1);
        check("d4_bad_bin", bin4, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
